// File: rtl/ysyx_220053_ifu.sv
// ysyx_220053_ifu -- instruction fetch unit.
//
// Holds the PC and fetches one 32-bit word at a time from instruction memory.
// At most one request is outstanding. The fetched word is presented to decode
// as {instr_o, pc_o} with a valid/ready handshake. Redirects from jumps and
// taken branches replace the PC, and any response already in flight is
// discarded, so stale data never reaches decode.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   imem_req_valid_o    fetch request valid (high only in REQ)
//   imem_req_addr_o     fetch address (current PC)
//   imem_req_ready_i    memory accepts the request this cycle
//   imem_resp_valid_i   response data valid (single-cycle pulse)
//   imem_resp_data_i    fetched instruction word
//   instr_valid_o       instruction available to decode
//   instr_o, pc_o       instruction word and its PC
//   instr_ready_i       decode consumes instr_o this cycle
//   redirect_i          change of flow
//   redirect_pc_i       redirect target
//   misalign_o          instr_o is a misaligned-target marker
//
// Optional feature macro: IFU_MISALIGN_CHECK_EN
//   defined   : misaligned redirect targets are kept as-is. Instead of fetching,
//               the unit presents a nop marker with misalign_o=1, then blocks
//               until the next redirect.
//   undefined : redirect targets are forced to word alignment, and misalign_o
//               is always 0.

module ysyx_220053_ifu #(
  parameter int unsigned       XLEN     = 64,
  parameter logic [XLEN-1:0]   RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_resp_valid_i,
  input  logic [31:0]     imem_resp_data_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            instr_ready_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            misalign_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {REQ, WAIT, DROP, HOLD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  // Set once a misaligned marker is consumed; fetch stays parked until a redirect.
  logic            blocked_q, blocked_d;

  logic [XLEN-1:0] target;
  logic            pc_mis;
  logic            req_valid;
  logic            handshake;

`ifdef IFU_MISALIGN_CHECK_EN
  assign target = redirect_pc_i;
  assign pc_mis = (pc_q[1:0] != 2'b00);
`else
  assign target = redirect_pc_i & ~XLEN'(3);
  assign pc_mis = 1'b0;
`endif

  assign req_valid = (state_q == REQ) && !pc_mis;
  assign handshake = req_valid && imem_req_ready_i;

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = pc_q;
  assign instr_valid_o    = valid_q;
  assign instr_o          = instr_q;
  assign pc_o             = pc_out_q;
  assign misalign_o       = mis_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    mis_d     = mis_q;
    blocked_d = blocked_q;
    case (state_q)
      REQ: begin
        if (redirect_i) begin
          pc_d      = target;
          blocked_d = 1'b0;
          // An accepted request with a redirect has a response to throw away.
          if (handshake) state_d = DROP;
        end else if (handshake) begin
          state_d = WAIT;
        end else if (pc_mis && !blocked_q) begin
          state_d  = HOLD;
          valid_d  = 1'b1;
          mis_d    = 1'b1;
          instr_d  = NOP;
          pc_out_d = pc_q;
        end
      end
      WAIT: begin
        if (imem_resp_valid_i) begin
          if (redirect_i) begin
            pc_d    = target;
            state_d = REQ;
          end else begin
            instr_d  = imem_resp_data_i;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            mis_d    = 1'b0;
            state_d  = HOLD;
          end
        end else if (redirect_i) begin
          pc_d    = target;
          state_d = DROP;
        end
      end
      DROP: begin
        if (redirect_i) pc_d = target;
        if (imem_resp_valid_i) state_d = REQ;
      end
      HOLD: begin
        if (redirect_i) begin
          valid_d   = 1'b0;
          mis_d     = 1'b0;
          blocked_d = 1'b0;
          pc_d      = target;
          state_d   = REQ;
        end else if (instr_ready_i) begin
          valid_d = 1'b0;
          mis_d   = 1'b0;
          state_d = REQ;
          // A consumed marker leaves the PC in place and parks fetch.
          if (mis_q) blocked_d = 1'b1;
          else       pc_d      = pc_q + XLEN'(4);
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      pc_out_q  <= '0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
      valid_q   <= valid_d;
      mis_q     <= mis_d;
      blocked_q <= blocked_d;
    end
  end

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
module tb_ysyx_220053_ifu;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid_o;
  logic [63:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        misalign_o;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int hs_base;

  ysyx_220053_ifu dut (
    .clk               (clk),
    .rst               (rst),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .instr_valid_o     (instr_valid_o),
    .instr_o           (instr_o),
    .pc_o              (pc_o),
    .instr_ready_i     (instr_ready_i),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .misalign_o        (misalign_o)
  );

  always #5 clk = ~clk;

  // Count request handshakes seen at each rising edge.
  always @(posedge clk) begin
    if (!rst && imem_req_valid_o && imem_req_ready_i) hs_cnt <= hs_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready_i = 1'b0;
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i = 32'h0;
    instr_ready_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 64'h0;
    tick();
    tick();
    chk("rst_instr_valid", 64'(instr_valid_o), 64'd0);
    chk("rst_instr", 64'(instr_o), 64'd0);
    chk("rst_pc_o", pc_o, 64'd0);
    chk("rst_misalign", 64'(misalign_o), 64'd0);
    chk("rst_addr", imem_req_addr_o, 64'h8000_0000);

    // First fetch: request right after reset release, response one cycle later.
    rst = 1'b0;
    imem_req_ready_i = 1'b1;
    chk("first_req_valid", 64'(imem_req_valid_o), 64'd1);
    chk("first_req_addr", imem_req_addr_o, 64'h8000_0000);
    tick();
    chk("wait_req_valid", 64'(imem_req_valid_o), 64'd0);
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'h0010_0093;
    tick();
    imem_resp_valid_i = 1'b0;
    chk("hold_valid", 64'(instr_valid_o), 64'd1);
    chk("hold_instr", 64'(instr_o), 64'h0010_0093);
    chk("hold_pc_o", pc_o, 64'h8000_0000);

    // Decode stalls for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 64'(instr_valid_o), 64'd1);
      chk("stall_instr", 64'(instr_o), 64'h0010_0093);
      chk("stall_pc_o", pc_o, 64'h8000_0000);
      chk("stall_no_req", 64'(imem_req_valid_o), 64'd0);
    end

    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    chk("next_valid_low", 64'(instr_valid_o), 64'd0);
    chk("next_req_valid", 64'(imem_req_valid_o), 64'd1);
    chk("next_req_addr", imem_req_addr_o, 64'h8000_0004);

    // Redirect while waiting; the old response must be dropped.
    tick();
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0100;
    tick();
    redirect_i = 1'b0;
    chk("drop_no_req", 64'(imem_req_valid_o), 64'd0);
    tick();
    chk("drop_idle_no_req", 64'(imem_req_valid_o), 64'd0);
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid_i = 1'b0;
    chk("drop_no_valid", 64'(instr_valid_o), 64'd0);
    chk("drop_req_valid", 64'(imem_req_valid_o), 64'd1);
    chk("drop_req_addr", imem_req_addr_o, 64'h8000_0100);

    // Redirect coincides with the response in WAIT.
    tick();
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'hCAFE_F00D;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0200;
    tick();
    imem_resp_valid_i = 1'b0;
    redirect_i = 1'b0;
    chk("coin_no_valid", 64'(instr_valid_o), 64'd0);
    chk("coin_req_valid", 64'(imem_req_valid_o), 64'd1);
    chk("coin_req_addr", imem_req_addr_o, 64'h8000_0200);

    // Memory not ready for 3 cycles, redirect in the middle.
    imem_req_ready_i = 1'b0;
    hs_base = hs_cnt;
    tick();
    chk("nr_addr0", imem_req_addr_o, 64'h8000_0200);
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0040;
    tick();
    redirect_i = 1'b0;
    chk("nr_addr1", imem_req_addr_o, 64'h8000_0040);
    chk("nr_valid1", 64'(imem_req_valid_o), 64'd1);
    tick();
    chk("nr_addr2", imem_req_addr_o, 64'h8000_0040);
    imem_req_ready_i = 1'b1;
    tick();
    chk("nr_wait", 64'(imem_req_valid_o), 64'd0);
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'h0000_0013;
    tick();
    imem_resp_valid_i = 1'b0;
    chk("nr_one_handshake", 64'(hs_cnt - hs_base), 64'd1);
    chk("nr_instr", 64'(instr_o), 64'h0000_0013);
    chk("nr_pc_o", pc_o, 64'h8000_0040);

    // Misaligned redirect from HOLD (simultaneous ready counts as consumed).
    redirect_i = 1'b1;
    instr_ready_i = 1'b1;
    redirect_pc_i = 64'h8000_0102;
    tick();
    redirect_i = 1'b0;
    instr_ready_i = 1'b0;
    chk("mr_valid_low", 64'(instr_valid_o), 64'd0);
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mr_no_req", 64'(imem_req_valid_o), 64'd0);
    tick();
    chk("mr_marker_valid", 64'(instr_valid_o), 64'd1);
    chk("mr_marker_flag", 64'(misalign_o), 64'd1);
    chk("mr_marker_pc", pc_o, 64'h8000_0102);
    chk("mr_marker_instr", 64'(instr_o), 64'h0000_0013);
    chk("mr_marker_no_req", 64'(imem_req_valid_o), 64'd0);
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    chk("mr_blk_valid", 64'(instr_valid_o), 64'd0);
    chk("mr_blk_req", 64'(imem_req_valid_o), 64'd0);
    tick();
    chk("mr_blk2_valid", 64'(instr_valid_o), 64'd0);
    chk("mr_blk2_req", 64'(imem_req_valid_o), 64'd0);
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0300;
    tick();
    redirect_i = 1'b0;
    chk("mr_unblock_req", 64'(imem_req_valid_o), 64'd1);
    chk("mr_unblock_addr", imem_req_addr_o, 64'h8000_0300);
`else
    chk("mr_req_valid", 64'(imem_req_valid_o), 64'd1);
    chk("mr_req_addr", imem_req_addr_o, 64'h8000_0100);
    chk("mr_misalign_low", 64'(misalign_o), 64'd0);
`endif

    // PC wrap at the top of the address space.
    imem_req_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    chk("wrap_addr", imem_req_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_req_ready_i = 1'b1;
    tick();
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'h0000_0073;
    tick();
    imem_resp_valid_i = 1'b0;
    chk("wrap_pc_o", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_instr", 64'(instr_o), 64'h0000_0073);
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    chk("wrap_next_addr", imem_req_addr_o, 64'h0);
    chk("wrap_next_req", 64'(imem_req_valid_o), 64'd1);

    // Reset while a request is in flight.
    tick();
    chk("inflight_wait", 64'(imem_req_valid_o), 64'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_req", 64'(imem_req_valid_o), 64'd1);
    chk("mid_rst_addr", imem_req_addr_o, 64'h8000_0000);
    chk("mid_rst_valid", 64'(instr_valid_o), 64'd0);
    chk("mid_rst_pc_o", pc_o, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
